uart_pkt_parser: RTL and testbench

Byte-level frame parser sitting directly downstream of the UART receiver. It consumes each single-cycle `valid` + byte pair, hunts for a sync byte, captures a length-prefixed payload, and verifies an 8-bit additive checksum. Verified payloads are replayed on a ready/valid byte stream to the command layer. Malformed or interrupted frames are dropped and flagged with one-cycle error pulses.

---
 rtl/uart_pkt_pkg.sv | 15 +
 rtl/uart_pkt_buf.sv | 24 ++
 rtl/uart_pkt_parser.sv | 181 ++++++++++++++++++
 tb/tb_uart_pkt_parser.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared definitions for the UART frame parser: FSM state encoding and the
// default frame start marker.
package uart_pkt_pkg;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_DRAIN
  } state_t;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_pkt_buf.sv
// Payload buffer: DEPTH x 8 register array, one synchronous write port and
// one combinational read port.
module uart_pkt_buf #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              i_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // NOTE: the array has no reset; every entry is written before it can be read.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_pkt_parser.sv
// Sync/length/checksum frame parser replaying verified payloads on a ready/valid
// byte stream. Define UART_PKT_TIMEOUT_EN to build the inter-byte timeout.
module uart_pkt_parser
  import uart_pkt_pkg::*;
#(
  parameter int         MAX_LEN      = 16,
  parameter logic [7:0] SYNC_BYTE    = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CLKS = 20000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx_data_valid,
  input  logic [7:0] i_rx_byte,
  output logic       o_out_valid,
  output logic [7:0] o_out_data,
  output logic       o_out_last,
  input  logic       i_out_ready,
  output logic       o_err_len,
  output logic       o_err_csum,
  output logic       o_err_overrun,
  output logic       o_err_timeout
);

  localparam int         CNT_W     = $clog2(MAX_LEN + 1);
  localparam int         ADDR_W    = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  if (MAX_LEN < 1 || MAX_LEN > 255 || TIMEOUT_CLKS < 2) begin : g_bad_param
    $error("uart_pkt_parser: parameter out of range");
  end

  state_t           state_q, state_d;
  logic [CNT_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic [7:0]       acc_q, acc_d;
  logic             err_len_q, err_len_d;
  logic             err_csum_q, err_csum_d;
  logic             err_ovr_q, err_ovr_d;
  logic             buf_we;
  logic [7:0]       buf_rdata;
  logic             idx_at_end;
  logic             timeout_hit;

  // One index serves as the write pointer while filling and the read pointer while draining.
  assign idx_at_end = (idx_q == len_q - 1'b1);

  always_comb begin
    // NOTE: every signal gets a default first so no path can infer a latch.
    state_d    = state_q;
    len_d      = len_q;
    idx_d      = idx_q;
    acc_d      = acc_q;
    err_len_d  = 1'b0;
    err_csum_d = 1'b0;
    err_ovr_d  = 1'b0;
    buf_we     = 1'b0;

    case (state_q)
      ST_HUNT: begin
        if (i_rx_data_valid && i_rx_byte == SYNC_BYTE) state_d = ST_LEN;
      end
      ST_LEN: begin
        if (i_rx_data_valid) begin
          if (i_rx_byte == 8'h00 || i_rx_byte > MAX_LEN_B) begin
            err_len_d = 1'b1;
            state_d   = ST_HUNT;
          end else begin
            len_d   = i_rx_byte[CNT_W-1:0];
            acc_d   = i_rx_byte;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
      end
      ST_PAYLOAD: begin
        if (i_rx_data_valid) begin
          buf_we = 1'b1;
          acc_d  = acc_q + i_rx_byte;
          if (idx_at_end) begin
            idx_d   = '0;
            state_d = ST_CHECK;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_CHECK: begin
        if (i_rx_data_valid) begin
          if (i_rx_byte == acc_q) begin
            idx_d   = '0;
            state_d = ST_DRAIN;
          end else begin
            err_csum_d = 1'b1;
            state_d    = ST_HUNT;
          end
        end
      end
      ST_DRAIN: begin
        err_ovr_d = i_rx_data_valid;
        if (i_out_ready) begin
          if (idx_at_end) begin
            idx_d   = '0;
            state_d = ST_HUNT;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase

    // timeout_hit already excludes cycles carrying a strobe, so the byte wins.
    if (timeout_hit) state_d = ST_HUNT;
  end

  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!i_rst_n) begin
      state_q    <= ST_HUNT;
      len_q      <= '0;
      idx_q      <= '0;
      acc_q      <= '0;
      err_len_q  <= 1'b0;
      err_csum_q <= 1'b0;
      err_ovr_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      acc_q      <= acc_d;
      err_len_q  <= err_len_d;
      err_csum_q <= err_csum_d;
      err_ovr_q  <= err_ovr_d;
    end
  end

  uart_pkt_buf #(
    .DEPTH (MAX_LEN),
    .ADDR_W(ADDR_W)
  ) u_buf (
    .i_clk  (i_clk),
    .wr_en  (buf_we),
    .wr_addr(idx_q[ADDR_W-1:0]),
    .wr_data(i_rx_byte),
    .rd_addr(idx_q[ADDR_W-1:0]),
    .rd_data(buf_rdata)
  );

`ifdef UART_PKT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CLKS + 1);

  logic [TO_W-1:0] to_cnt_q;
  logic            to_active;
  logic            err_to_q;

  // to_cnt_q holds clocks elapsed since the last strobe, so the pulse lands
  // exactly TIMEOUT_CLKS clocks after it.
  assign to_active   = state_q inside {ST_LEN, ST_PAYLOAD, ST_CHECK};
  assign timeout_hit = to_active && !i_rx_data_valid &&
                       (to_cnt_q == TO_W'(TIMEOUT_CLKS - 1));

  always_ff @(posedge i_clk) begin
    if (!i_rst_n || i_rx_data_valid || !to_active) to_cnt_q <= TO_W'(1);
    else                                           to_cnt_q <= to_cnt_q + 1'b1;
    err_to_q <= i_rst_n && timeout_hit;
  end

  assign o_err_timeout = err_to_q;
`else
  assign timeout_hit   = 1'b0;
  assign o_err_timeout = 1'b0;
`endif

  assign o_out_valid   = (state_q == ST_DRAIN);
  assign o_out_data    = o_out_valid ? buf_rdata : 8'h00;
  assign o_out_last    = o_out_valid && idx_at_end;
  assign o_err_len     = err_len_q;
  assign o_err_csum    = err_csum_q;
  assign o_err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Scoreboard bench for uart_pkt_parser: expected payload beats are queued as
// frames are sent and popped by a monitor on every accepted output beat.
module tb_uart_pkt_parser;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       out_ready = 1'b0;
  logic       out_valid, out_last;
  logic [7:0] out_data;
  logic       err_len, err_csum, err_ovr, err_to;

  int checks = 0;
  int errors = 0;
  int seen_len = 0, seen_csum = 0, seen_ovr = 0, seen_to = 0;
  int exp_len = 0, exp_csum = 0, exp_ovr = 0, exp_to = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  uart_pkt_parser #(
    .MAX_LEN     (16),
    .SYNC_BYTE   (8'hA5),
    .TIMEOUT_CLKS(100)
  ) dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_rx_data_valid(rx_valid),
    .i_rx_byte      (rx_byte),
    .o_out_valid    (out_valid),
    .o_out_data     (out_data),
    .o_out_last     (out_last),
    .i_out_ready    (out_ready),
    .o_err_len      (err_len),
    .o_err_csum     (err_csum),
    .o_err_overrun  (err_ovr),
    .o_err_timeout  (err_to)
  );

  // Monitor: pop the scoreboard on each accepted beat, count error-pulse cycles.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL out_unexpected: got data %02h last %0b, expected no beat", out_data, out_last);
        end else begin
          exp_t e;
          e = sb.pop_front();
          if (out_data !== e.data || out_last !== e.last) begin
            errors++;
            $display("FAIL out_beat: got data %02h last %0b, expected data %02h last %0b",
                     out_data, out_last, e.data, e.last);
          end
        end
      end
      if (err_len === 1'b1)  seen_len++;
      if (err_csum === 1'b1) seen_csum++;
      if (err_ovr === 1'b1)  seen_ovr++;
      if (err_to === 1'b1)   seen_to++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic send_raw(input logic [7:0] bytes[$]);
    foreach (bytes[i]) begin
      rx_valid = 1'b1;
      rx_byte  = bytes[i];
      next_cycle();
    end
    rx_valid = 1'b0;
    rx_byte  = 8'h00;
  endtask

  // Builds SYNC, LEN, payload, CSUM; queues the payload when delivery is expected.
  task automatic send_good(input logic [7:0] pl[$], input bit expect_out);
    logic [7:0] fr[$];
    logic [7:0] sum;
    sum = 8'(pl.size());
    fr.push_back(8'hA5);
    fr.push_back(8'(pl.size()));
    foreach (pl[i]) begin
      fr.push_back(pl[i]);
      sum = sum + pl[i];
      if (expect_out) sb.push_back('{data: pl[i], last: (i == pl.size() - 1)});
    end
    fr.push_back(sum);
    send_raw(fr);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!out_valid && sb.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s_drain: valid %0b pending %0d, expected idle with 0 pending", tag, out_valid, sb.size());
    end
    next_cycle();
  endtask

  task automatic expect_outputs_zero(input string tag);
    checks++;
    if ({out_valid, out_data, out_last, err_len, err_csum, err_ovr, err_to} !== 14'h0) begin
      errors++;
      $display("FAIL %s: got valid %0b data %02h last %0b errs %0b%0b%0b%0b, expected all 0",
               tag, out_valid, out_data, out_last, err_len, err_csum, err_ovr, err_to);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) next_cycle();
    @(negedge clk);
    expect_outputs_zero("reset_values");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_good_frame();
    out_ready = 1'b1;
    send_good('{8'h11, 8'h22, 8'h33}, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'h11) begin
      errors++;
      $display("FAIL good_first_beat: got valid %0b data %02h, expected valid 1 data 11", out_valid, out_data);
    end
    wait_idle("good");
  endtask

  task automatic test_bad_csum();
    out_ready = 1'b1;
    send_raw('{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A});
    exp_csum++;
    @(negedge clk);
    checks++;
    if (err_csum !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL csum_pulse: got err_csum %0b valid %0b, expected err_csum 1 valid 0", err_csum, out_valid);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (err_csum !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL csum_width: got err_csum %0b valid %0b, expected 0 0", err_csum, out_valid);
    end
    next_cycle();
    send_good('{8'h11, 8'h22, 8'h33}, 1'b1);
    wait_idle("after_csum");
  endtask

  task automatic test_bad_len();
    logic [7:0] lens[2] = '{8'h00, 8'h11};
    out_ready = 1'b1;
    foreach (lens[i]) begin
      send_raw('{8'hA5, lens[i]});
      exp_len++;
      @(negedge clk);
      checks++;
      if (err_len !== 1'b1) begin
        errors++;
        $display("FAIL len_pulse: LEN %02h got err_len %0b, expected 1", lens[i], err_len);
      end
      next_cycle();
    end
    send_good('{8'h42}, 1'b1);
    wait_idle("after_len");
  endtask

  task automatic test_stall_sync();
    out_ready = 1'b1;
    send_good('{8'hA5, 8'h7E}, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL stall_beat0: got valid %0b data %02h last %0b, expected 1 A5 0", out_valid, out_data, out_last);
    end
    next_cycle();
    out_ready = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1 || out_data !== 8'h7E || out_last !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold: cycle %0d got valid %0b data %02h last %0b, expected 1 7E 1",
                 s, out_valid, out_data, out_last);
      end
      next_cycle();
    end
    out_ready = 1'b1;
    wait_idle("stall");
  endtask

  task automatic test_overrun();
    out_ready = 1'b0;
    send_good('{8'hC3, 8'h3C}, 1'b1);
    next_cycle();
    send_raw('{8'h55});
    exp_ovr++;
    @(negedge clk);
    checks++;
    if (err_ovr !== 1'b1 || out_valid !== 1'b1 || out_data !== 8'hC3) begin
      errors++;
      $display("FAIL overrun_pulse: got err_ovr %0b valid %0b data %02h, expected 1 1 C3", err_ovr, out_valid, out_data);
    end
    next_cycle();
    @(negedge clk);
    checks++;
    if (err_ovr !== 1'b0) begin
      errors++;
      $display("FAIL overrun_width: got err_ovr %0b, expected 0", err_ovr);
    end
    next_cycle();
    out_ready = 1'b1;
    wait_idle("overrun");
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    send_good('{8'h10}, 1'b1);
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_data !== 8'h10) begin
      errors++;
      $display("FAIL b2b_last: got valid %0b data %02h last %0b, expected 1 10 1", out_valid, out_data, out_last);
    end
    next_cycle();
    send_good('{8'h20, 8'h21}, 1'b1);
    wait_idle("b2b");
  endtask

  task automatic test_random();
    bit done = 1'b0;
    fork
      begin
        for (int f = 0; f < 6; f++) begin
          logic [7:0] pl[$];
          int n;
          n = (f == 0) ? 16 : int'($urandom_range(1, 16));
          for (int k = 0; k < n; k++) pl.push_back(8'($urandom_range(0, 255)));
          send_good(pl, 1'b1);
          wait_idle("random");
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          out_ready = 1'($urandom_range(0, 1));
          next_cycle();
        end
      end
    join
    out_ready = 1'b1;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1;
    send_raw('{8'hA5, 8'h05, 8'h01, 8'h02});
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    expect_outputs_zero("reset_mid_payload");
    next_cycle();
    rst_n = 1'b1;
    send_good('{8'h77}, 1'b1);
    wait_idle("after_reset_payload");

    out_ready = 1'b0;
    send_good('{8'h99}, 1'b0);
    rst_n = 1'b0;
    next_cycle();
    @(negedge clk);
    expect_outputs_zero("reset_mid_drain");
    next_cycle();
    rst_n = 1'b1;
    next_cycle();
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_drain_idle: got valid %0b, expected 0", out_valid);
    end
    next_cycle();
    out_ready = 1'b1;
  endtask

`ifdef UART_PKT_TIMEOUT_EN
  task automatic test_timeout();
    out_ready = 1'b1;
    send_raw('{8'hA5, 8'h03, 8'h11});
    exp_to++;
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      if (k >= 98) begin
        checks++;
        if (err_to !== (k == 100)) begin
          errors++;
          $display("FAIL timeout_pulse: clock %0d after byte got %0b, expected %0b", k, err_to, (k == 100));
        end
      end
    end
    next_cycle();
    send_good('{8'h01, 8'h02, 8'h03}, 1'b1);
    wait_idle("after_timeout");
  endtask
`endif

  task automatic test_final_counts();
    int seen[4];
    int want[4];
    string names[4] = '{"err_len_count", "err_csum_count", "err_overrun_count", "err_timeout_count"};
    seen = '{seen_len, seen_csum, seen_ovr, seen_to};
    want = '{exp_len, exp_csum, exp_ovr, exp_to};
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (seen[i] !== want[i]) begin
        errors++;
        $display("FAIL %s: got %0d pulse cycles, expected %0d", names[i], seen[i], want[i]);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %0d pending beats, expected 0", sb.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_csum();
    test_bad_len();
    test_stall_sync();
    test_overrun();
    test_back_to_back();
    test_random();
    test_reset_mid();
`ifdef UART_PKT_TIMEOUT_EN
    test_timeout();
`endif
    test_final_counts();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
